// File: rtl/ram_responder_if.sv
// Request/response bundle between the memory controller and the RAM responder.
// The master side drives the request stream, the slave side returns data and status.
interface ram_responder_if;
    logic        Ren;
    logic        Wen;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        busy_o;
    logic        err_o;

    modport master (
        output Ren, Wen, ramaddr, ramstore,
        input  ramload, busy_o, err_o
    );

    modport slave (
        input  Ren, Wen, ramaddr, ramstore,
        output ramload, busy_o, err_o
    );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM model with a fixed, parameterized access latency.
// It serves one held Ren/Wen request at a time and acknowledges it with a single busy_o-low cycle.
module ram_responder #(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 1024
) (
    input  logic            CLK,
    input  logic            nRST,
    ram_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            is_read_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     data_q;
    logic [31:0]     ramload_q;
    logic            busy_q;
    logic            err_q;

    logic [31:0]     mem [DEPTH];

    logic            req;
    logic [AW-1:0]   live_idx;
    logic            commit;
    logic            commit_read;
    logic [AW-1:0]   commit_idx;
    logic [31:0]     commit_data;
    logic            unused_addr;

    assign req         = bus.Ren | bus.Wen;
    assign live_idx    = bus.ramaddr[2 +: AW];
    assign unused_addr = ^bus.ramaddr;

    // With zero latency the access happens on the capture edge, so it uses the live inputs.
    always_comb begin
        commit      = 1'b0;
        commit_read = is_read_q;
        commit_idx  = idx_q;
        commit_data = data_q;
        unique case (state_q)
            StIdle: begin
                if (LAT == 0 && req) begin
                    commit      = 1'b1;
                    commit_read = bus.Ren;
                    commit_idx  = live_idx;
                    commit_data = bus.ramstore;
                end
            end
            StWait:  commit = req && (cnt_q <= 4'd1);
            default: commit = 1'b0;
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (commit && !commit_read) begin
            mem[commit_idx] <= commit_data;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            is_read_q <= 1'b0;
            idx_q     <= '0;
            data_q    <= 32'd0;
            ramload_q <= 32'd0;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            busy_q <= 1'b1;
            err_q  <= 1'b0;
            if (commit && commit_read) begin
                ramload_q <= mem[commit_idx];
            end
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        is_read_q <= bus.Ren;
                        idx_q     <= live_idx;
                        data_q    <= bus.ramstore;
                        cnt_q     <= 4'(LAT);
                        err_q     <= bus.Ren & bus.Wen;
                        if (LAT == 0) begin
                            state_q <= StAck;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    // A dropped request abandons the access before any commit.
                    if (!req) begin
                        state_q <= StIdle;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q <= 4'd1) begin
                        state_q <= StAck;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StAck:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ramload = ramload_q;
    assign bus.busy_o  = busy_q;
    assign bus.err_o   = err_q;
endmodule

// File: doc/ram_responder.md
# ram_responder

RAM-side responder for the CPU memory bus. It serves the single `ramaddr`/`ramstore`/`Ren`/`Wen` request stream from the memory controller and returns `ramload` and `busy_o`. It holds a word-addressed storage array and models a fixed, parameterized access latency. It is the far end of the memory controller's RAM interface and stands in for the real RAM in simulation and FPGA builds.

## Interface
- `LAT`, 2: wait cycles between request capture and acknowledge; legal range 0..15.
- `DEPTH`, 1024: storage size in 32-bit words; power of two.
- `CLK` in 1: sole clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `Ren` in 1: read request; held by requester until acknowledged.
- `Wen` in 1: write request; held by requester until acknowledged.
- `ramaddr` in 32: byte address; word index = `ramaddr[2 +: log2(DEPTH)]`; bits [1:0] and upper bits ignored (aliasing).
- `ramstore` in 32: write data.
- `ramload` out 32: read data, registered.
- `busy_o` out 1: 0 only in the single acknowledge cycle; 1 otherwise.
- `err_o` out 1: one-cycle pulse when `Ren` and `Wen` are both high at capture.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - On `Ren|Wen`, capture `ramaddr`, `ramstore`, and op; op = read if `Ren`.
  - Load counter with `LAT`.
  - Go to WAIT if `LAT>0`, else ACK.
  - No request: stay.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where counter reaches 0, go to ACK. For a write, commit `mem[idx] <= captured data` on that edge. For a read, `ramload <= mem[idx]` on that edge.
  - With `LAT=0`, the commit or load happens on the IDLE→ACK edge.
- ACK: `busy_o=0` for exactly one cycle, then unconditionally IDLE.
- Abort: if `Ren` and `Wen` are both low in WAIT, return to IDLE. No write commit, `ramload` unchanged, no ACK.
- Captured address, data, and op are used for the whole transaction. Changes on inputs after capture are ignored, except the abort check.
- Both `Ren` and `Wen` high at capture: treated as read; `err_o` pulses in the cycle after capture.
- A write does not change `ramload`.
- Storage is not reset. Contents are undefined until written or preloaded; preload is outside this block.

## Timing
- Reset values: state IDLE, `busy_o=1`, `ramload=0`, `err_o=0`, counter 0. Reset is asynchronous at any state. A write in progress is discarded and never committed.
- `busy_o` and `err_o` are decoded from registered state only, with no combinational path from inputs.
- Request first seen high in cycle 0 (sampled at the end of cycle 0):
  - ACK is in cycle `LAT+1`.
  - `ramload` is valid in cycle `LAT+1` and held until the next completed read.
- Write data is visible to a read captured in any cycle after the ACK cycle.
- Requester handshake: `ready = (Ren|Wen) & ~busy_o` in the ACK cycle. The requester may drop or change its request from the next cycle.
- A request still held during ACK is not re-captured in ACK. After ACK, IDLE samples it and starts a new transaction.
- Back-to-back throughput: one access per `LAT+2` cycles, including one IDLE capture cycle.
- Counter width is 4 bits. Counter decrements only in WAIT and never underflows.

## Test plan
- Write then read, `LAT=2`:
  - Write: `Wen=1`, `ramaddr=0x100`, `ramstore=0xDEADBEEF` from cycle 0 → `busy_o` = 1 in cycles 0–2, 0 in cycle 3.
  - Read: `Ren=1`, `ramaddr=0x100` → `ramload=0xDEADBEEF` in its cycle 3, `busy_o=0` in that cycle only.
- `LAT=0`: write `0x8`/`0x12345678`, then read `0x8` → ACK in cycle 1 of each request; `ramload=0x12345678`.
- Abort:
  - Pre-write `0x40=0x11111111`.
  - Start a write of `0x40=0xAAAAAAAA` with `LAT=3`, deassert `Wen` in cycle 2.
  - Required: no ACK; state back to IDLE; a later read of `0x40` returns `0x11111111`.
- Reset mid-transaction: assert `nRST=0` in cycle 1 of a write to `0x20` → outputs immediately `busy_o=1`, `ramload=0`. A later read of `0x20` does not return the aborted data.
- Conflict: `Ren=Wen=1` at `0x4`, `ramstore=0xFFFFFFFF`, with `0x4` previously `0x5` → `err_o` pulses in cycle 1; read performed; `ramload=0x5`; memory unchanged.
- Aliasing/stability, `DEPTH=1024`:
  - Write `0x1004=0xCAFE0001`; read `0x0004` → `0xCAFE0001`.
  - Change `ramaddr` during WAIT → captured address used.
